light_sequencer: RTL and testbench

- Generates the colour inputs (green, yellow, red) and the 6-bit phase timer consumed by scp_079.
- Closes the loop on scp_079's alarm outputs a1/a2/a3: any alarm forces a red lockdown.
- Replaces hand-driven bench stimulus with a synthesizable, parameterised source for the same interface.

---
 rtl/light_sequencer.sv | 111 +++++++++++
 tb/tb_light_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/light_sequencer.sv
// Phase sequencer that drives scp_079's colour and timer inputs. Any alarm
// from scp_079 forces a red lockdown that lasts until the alarm clears.
module light_sequencer #(
  parameter int GREEN_TIME  = 35,
  parameter int YELLOW_TIME = 5,
  parameter int RED_TIME    = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hold,
  input  logic [2:0] alarm,
  output logic       green,
  output logic       yellow,
  output logic       red,
  output logic [5:0] timer,
  output logic [1:0] phase,
  output logic       phase_done,
  output logic [7:0] cycle_count
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_RED    = 2'd2,
    PH_LOCK   = 2'd3
  } phase_t;

  localparam logic [5:0] GREEN_LAST  = 6'(GREEN_TIME - 1);
  localparam logic [5:0] YELLOW_LAST = 6'(YELLOW_TIME - 1);
  localparam logic [5:0] RED_LAST    = 6'(RED_TIME - 1);

  phase_t     phase_q, phase_n;
  logic [5:0] timer_q, timer_n;
  logic       done_q, done_n;
  logic [7:0] cnt_q, cnt_n;
  logic       alarm_any;

  // Lockdown timer stops at its maximum instead of wrapping back to zero.
  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  function automatic logic [5:0] last_tick(input phase_t p);
    case (p)
      PH_YELLOW: return YELLOW_LAST;
      PH_RED:    return RED_LAST;
      default:   return GREEN_LAST;
    endcase
  endfunction

  function automatic phase_t next_timed(input phase_t p);
    case (p)
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_GREEN;
    endcase
  endfunction

  assign alarm_any = |alarm;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= PH_GREEN;
      timer_q <= 6'd0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      phase_q <= phase_n;
      timer_q <= timer_n;
      done_q  <= done_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next-state logic: alarm outranks phase end and hold; LOCK ignores hold.
  always_comb begin
    phase_n = phase_q;
    timer_n = timer_q;
    done_n  = 1'b0;
    cnt_n   = cnt_q;
    if (alarm_any) begin
      phase_n = PH_LOCK;
      timer_n = (phase_q == PH_LOCK) ? sat_inc(timer_q) : 6'd0;
    end else if (phase_q == PH_LOCK) begin
      phase_n = PH_GREEN;
      timer_n = 6'd0;
    end else if (!hold) begin
      if (timer_q == last_tick(phase_q)) begin
        phase_n = next_timed(phase_q);
        timer_n = 6'd0;
        done_n  = 1'b1;
        if (phase_q == PH_RED) cnt_n = cnt_q + 8'd1;
      end else begin
        timer_n = timer_q + 6'd1;
      end
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    green       = (phase_q == PH_GREEN);
    yellow      = (phase_q == PH_YELLOW);
    red         = (phase_q == PH_RED) || (phase_q == PH_LOCK);
    timer       = timer_q;
    phase       = phase_q;
    phase_done  = done_q;
    cycle_count = cnt_q;
  end

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: a default-timed and an all-ones-timed
// instance run side by side against an abstract phase model.
module tb_light_sequencer;

  typedef struct packed {
    logic       g;
    logic       y;
    logic       r;
    logic [5:0] tm;
    logic [1:0] ph;
    logic       pd;
    logic [7:0] cc;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hold = 1'b0;
  logic [2:0] alarm = 3'd0;

  logic       g0, y0, r0, pd0, g1, y1, r1, pd1;
  logic [5:0] tm0, tm1;
  logic [1:0] ph0, ph1;
  logic [7:0] cc0, cc1;

  int n_cmp = 0;
  int n_err = 0;

  obs_t q0[$];
  obs_t q1[$];

  // Model state per instance: phase index (3 = lock), elapsed cycles, done flag, rounds.
  int lens [2][3] = '{'{35, 5, 25}, '{1, 1, 1}};
  int m_ph [2];
  int m_tm [2];
  int m_pd [2];
  int m_cc [2];

  always #5 clk = ~clk;

  light_sequencer dut0 (
    .clock(clk), .reset(reset), .hold(hold), .alarm(alarm),
    .green(g0), .yellow(y0), .red(r0), .timer(tm0), .phase(ph0),
    .phase_done(pd0), .cycle_count(cc0)
  );

  light_sequencer #(.GREEN_TIME(1), .YELLOW_TIME(1), .RED_TIME(1)) dut1 (
    .clock(clk), .reset(reset), .hold(hold), .alarm(alarm),
    .green(g1), .yellow(y1), .red(r1), .timer(tm1), .phase(ph1),
    .phase_done(pd1), .cycle_count(cc1)
  );

  function automatic obs_t expect_of(int k);
    obs_t e;
    e.g  = (m_ph[k] == 0);
    e.y  = (m_ph[k] == 1);
    e.r  = (m_ph[k] >= 2);
    e.tm = 6'(m_tm[k]);
    e.ph = 2'(m_ph[k]);
    e.pd = 1'(m_pd[k]);
    e.cc = 8'(m_cc[k]);
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_tm[k] = 0; m_pd[k] = 0; m_cc[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit h, input logic [2:0] a);
    m_pd[k] = 0;
    if (a != 0) begin
      m_tm[k] = (m_ph[k] == 3) ? ((m_tm[k] < 63) ? m_tm[k] + 1 : 63) : 0;
      m_ph[k] = 3;
    end else if (m_ph[k] == 3) begin
      m_ph[k] = 0;
      m_tm[k] = 0;
    end else if (!h) begin
      if (m_tm[k] + 1 == lens[k][m_ph[k]]) begin
        m_pd[k] = 1;
        if (m_ph[k] == 2) m_cc[k] = (m_cc[k] + 1) % 256;
        m_ph[k] = (m_ph[k] + 1) % 3;
        m_tm[k] = 0;
      end else begin
        m_tm[k] = m_tm[k] + 1;
      end
    end
  endtask

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got g%0b y%0b r%0b tm=%0d ph=%0d pd=%0b cc=%0d, expected g%0b y%0b r%0b tm=%0d ph=%0d pd=%0b cc=%0d",
               name, act.g, act.y, act.r, act.tm, act.ph, act.pd, act.cc,
               exp.g, exp.y, exp.r, exp.tm, exp.ph, exp.pd, exp.cc);
    end
  endtask

  // Called at a falling edge: drives inputs for the next rising edge and queues the expectation.
  task automatic cycle(input bit h, input logic [2:0] a);
    hold  = h;
    alarm = a;
    for (int k = 0; k < 2; k++) model_step(k, h, a);
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
    @(negedge clk);
  endtask

  task automatic run_until(input int ph, input int tm);
    for (int i = 0; i < 400; i++) begin
      if (m_ph[0] == ph && m_tm[0] == tm) return;
      cycle(1'b0, 3'd0);
    end
    n_cmp++;
    n_err++;
    $display("FAIL run_until: never reached ph=%0d tm=%0d, stuck at ph=%0d tm=%0d", ph, tm, m_ph[0], m_tm[0]);
  endtask

  function automatic obs_t act0();
    return {g0, y0, r0, tm0, ph0, pd0, cc0};
  endfunction

  function automatic obs_t act1();
    return {g1, y1, r1, tm1, ph1, pd1, cc1};
  endfunction

  // Monitor: pops one expectation per instance after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) compare("dut0_step", act0(), q0.pop_front());
      if (q1.size() > 0) compare("dut1_step", act1(), q1.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    compare("reset0", act0(), expect_of(0));
    compare("reset1", act1(), expect_of(1));
    @(negedge clk);
    reset = 1'b0;

    // Free-running defaults through one full round and into the next.
    for (int i = 0; i < 70; i++) cycle(1'b0, 3'd0);

    run_until(0, 20);
    for (int i = 0; i < 10; i++) cycle(1'b1, 3'd0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 3'd0);

    run_until(1, 2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'b010);
    for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0);

    for (int i = 0; i < 80; i++) cycle(1'b0, 3'b001);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0);

    // Alarm lands on the final RED tick; hold is also high to show it is outranked.
    run_until(2, 24);
    cycle(1'b1, 3'b100);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0);

    // Asynchronous reset pulse between edges, mid-RED.
    run_until(2, 10);
    #7;
    reset = 1'b1;
    #1;
    model_reset();
    compare("async_reset0", act0(), expect_of(0));
    compare("async_reset1", act1(), expect_of(1));
    #1;
    reset = 1'b0;
    @(negedge clk);

    // Long clean run: the unit-timed instance completes over 256 rounds and wraps.
    for (int i = 0; i < 800; i++) cycle(1'b0, 3'd0);

    for (int i = 0; i < 2000; i++) begin
      bit h;
      logic [2:0] a;
      h = ($urandom_range(3) == 0);
      a = ($urandom_range(15) == 0) ? 3'($urandom_range(7, 1)) : 3'd0;
      cycle(h, a);
    end
    cycle(1'b0, 3'd0);

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
